// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter and the hazard/stall logic.
package mem_port_arbiter_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        RESP   = 2'd3
    } arbState_t;

    // Requester identifiers.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Wait counter for an outstanding memory command.
// Loading restarts the count from zero, and the count then advances on inc.
// The done flag marks the last allowed wait cycle (TIMEOUT-1).
module arb_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic done
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count wait cycles, holding at the terminal value.
    // NOTE: sequential state uses <= so every register samples pre-edge values,
    // independent of statement or process order.
    // NOTE: only control/state registers exist here; all are reset asynchronously
    // so the arbiter is quiescent the instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc && !done) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by fetch (IF) and MEM (DM).
// DM wins simultaneous requests unless IF has been passed over STARVE_LIMIT times.
// Each grant waits for mem_ack, or aborts after TIMEOUT cycles with err set.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    arbState_t     state;
    arbState_t     nextState;
    logic [SW-1:0] streak;
    logic          grantIf;
    logic          grantDm;
    logic          inGrant;
    logic          ackHit;
    logic          timeoutHit;
    logic          timeoutDone;
    logic          winner;

    arb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .load (grantIf || grantDm),
        .inc  (inGrant && !mem_ack),
        .done (timeoutDone)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Arbitration decision and next-state decode.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState  = state;
        grantIf    = 1'b0;
        grantDm    = 1'b0;
        inGrant    = 1'b0;
        ackHit     = 1'b0;
        timeoutHit = 1'b0;
        winner     = REQ_IF;
        unique case (state)
            IDLE: begin
                if (dm_req && !(if_req && streak == STREAK_MAX)) begin
                    grantDm   = 1'b1;
                    nextState = GNT_DM;
                end else if (if_req) begin
                    grantIf   = 1'b1;
                    nextState = GNT_IF;
                end
            end
            GNT_IF, GNT_DM: begin
                inGrant = 1'b1;
                winner  = (state == GNT_DM) ? REQ_DM : REQ_IF;
                // A late ack still counts as success even on the last wait cycle.
                if (mem_ack) begin
                    ackHit    = 1'b1;
                    nextState = RESP;
                end else if (timeoutDone) begin
                    timeoutHit = 1'b1;
                    nextState  = RESP;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Memory command, completion pulses, read data and starvation streak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            err       <= 1'b0;
            streak    <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            err      <= 1'b0;

            if (grantDm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                if (if_req) begin
                    streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
                end else begin
                    streak <= '0;
                end
            end

            if (grantIf) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                streak   <= '0;
            end

            if (ackHit || timeoutHit) begin
                mem_req <= 1'b0;
                err     <= timeoutHit;
                if (winner == REQ_DM) begin
                    dm_valid <= 1'b1;
                    if (!mem_we) begin
                        dm_rdata <= ackHit ? mem_rdata : '0;
                    end
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= ackHit ? mem_rdata : '0;
                end
            end
        end
    end

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural memory answers
// commands, and a scoreboard of expected completions is compared on each valid.
module tb_mem_port_arbiter;

    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;

    typedef struct {
        bit          isDm;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } expect_t;

    expect_t     expQ[$];
    logic [31:0] grantQ[$];
    int          checks     = 0;
    int          errors     = 0;
    int          cyc        = 0;
    int          riseCyc    = 0;
    int          validsSeen = 0;
    int          memCnt     = 0;
    int          ackDelay   = 0;
    bit          ackEn      = 1'b1;
    bit          prevMemReq = 1'b0;
    bit          dropOnValid = 1'b1;
    logic [31:0] dmRdataModel = '0;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hDEAD_BEFF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, run the memory model, then score any completion.
    task automatic stepCycle();
        expect_t e;
        @(negedge clk);
        cyc++;
        if (mem_req && !rst) begin
            if (!prevMemReq) begin
                riseCyc = cyc;
                grantQ.push_back(mem_addr);
            end
            if (ackEn && memCnt == ackDelay) begin
                mem_ack   = 1'b1;
                mem_rdata = memData(mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
            memCnt++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            memCnt    = 0;
        end
        prevMemReq = mem_req;

        if (if_valid || dm_valid) begin
            validsSeen++;
            if (if_valid && dm_valid) check("both_valid", 2'b11, 2'b01);
            if (expQ.size() == 0) begin
                check("unexpected_valid", {if_valid, dm_valid}, 2'b00);
            end else begin
                e = expQ.pop_front();
                check("who_dm", dm_valid, e.isDm);
                check("rdata", e.isDm ? dm_rdata : if_rdata, e.rdata);
                check("err", err, e.err);
                if (e.lat >= 0) check("latency", cyc - riseCyc, e.lat);
            end
            if (dropOnValid) begin
                if (if_valid) if_req = 1'b0;
                if (dm_valid) dm_req = 1'b0;
            end
        end
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            stepCycle();
            n++;
        end
        check({tag, "_outstanding"}, expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_cmd", {mem_we, mem_addr, mem_wdata}, 0);
        check("rst_valids", {if_valid, dm_valid, err}, 0);
        check("rst_rdata", {if_rdata, dm_rdata}, 0);
        stepCycle();
        stepCycle();
        rst = 1'b0;

        // Single IF read, ack two cycles after mem_req.
        expQ.push_back('{1'b0, memData(32'h10), 1'b0, 3});
        if_addr = 32'h10; if_req = 1'b1; ackEn = 1'b1; ackDelay = 2;
        stepCycle();
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 32'h10);
        check("t1_mem_we", mem_we, 0);
        n = 0;
        while (expQ.size() != 0 && n < 10) begin
            check("t1_stall_if", stall_if, 1);
            stepCycle();
            n++;
        end
        check("t1_outstanding", expQ.size(), 0);
        check("t1_mem_req_resp", mem_req, 0);
        stepCycle();

        // Both requesters held with immediate acks: DM x4 then IF, twice.
        ackDelay = 0; dm_we = 1'b0; if_addr = 32'h100; dm_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) expQ.push_back('{1'b0, memData(32'h100), 1'b0, 1});
            else            expQ.push_back('{1'b1, memData(32'h200), 1'b0, 1});
        end
        dmRdataModel = memData(32'h200);
        grantQ.delete(); validsSeen = 0; dropOnValid = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        n = 0;
        while (validsSeen < 10 && n < 100) begin
            stepCycle();
            n++;
        end
        if_req = 1'b0; dm_req = 1'b0; dropOnValid = 1'b1;
        repeat (4) stepCycle();
        check("t3_valids", validsSeen, 10);
        check("t3_outstanding", expQ.size(), 0);
        check("t3_grants", grantQ.size(), 10);
        for (int i = 0; i < grantQ.size(); i++)
            check($sformatf("t3_grant%0d", i), grantQ[i], (i % 5 == 4) ? 32'h100 : 32'h200);
        expQ.delete();

        // DM write with zero-wait ack; dm_rdata keeps the previous read value.
        expQ.push_back('{1'b1, dmRdataModel, 1'b0, 1});
        dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234; dm_req = 1'b1;
        stepCycle();
        check("t2_mem_req", mem_req, 1);
        check("t2_mem_we", mem_we, 1);
        check("t2_mem_addr", mem_addr, 32'h40);
        check("t2_mem_wdata", mem_wdata, 32'h1234);
        waitDone("t2", 10);
        stepCycle();
        dm_we = 1'b0;

        // IF read with no ack: timeout after TIMEOUT cycles, then a clean follow-up.
        ackEn = 1'b0;
        expQ.push_back('{1'b0, 32'h0, 1'b1, TIMEOUT});
        if_addr = 32'h20; if_req = 1'b1;
        waitDone("t4", 40);
        check("t4_mem_req_resp", mem_req, 0);
        stepCycle();
        ackEn = 1'b1; ackDelay = 0;
        expQ.push_back('{1'b0, memData(32'h24), 1'b0, 1});
        if_addr = 32'h24; if_req = 1'b1;
        waitDone("t4b", 10);
        stepCycle();

        // Requester address change during GNT_DM is ignored.
        ackDelay = 3;
        expQ.push_back('{1'b1, memData(32'h40), 1'b0, 4});
        dmRdataModel = memData(32'h40);
        dm_addr = 32'h40; dm_req = 1'b1;
        stepCycle();
        check("t6_mem_addr", mem_addr, 32'h40);
        dm_addr = 32'h80;
        n = 0;
        while (expQ.size() != 0 && n < 20) begin
            stepCycle();
            if (mem_req) check("t6_mem_addr_hold", mem_addr, 32'h40);
            n++;
        end
        check("t6_outstanding", expQ.size(), 0);
        stepCycle();

        // Reset while in GNT_DM abandons the transaction; a fresh one follows.
        ackEn = 1'b0;
        expQ.push_back('{1'b1, memData(32'h300), 1'b0, -1});
        dm_addr = 32'h300; dm_req = 1'b1;
        repeat (3) stepCycle();
        check("t5_mem_req_pre", mem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_mem_req_rst", mem_req, 0);
        check("t5_dm_valid_rst", dm_valid, 0);
        expQ.delete();
        dmRdataModel = '0;
        repeat (2) stepCycle();
        check("t5_dm_rdata_rst", dm_rdata, dmRdataModel);
        rst = 1'b0; ackEn = 1'b1; ackDelay = 1;
        expQ.push_back('{1'b1, memData(32'h300), 1'b0, 2});
        waitDone("t5", 20);
        repeat (3) stepCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-ported, variable-latency unified memory shared by the fetch stage (IF requester) and the MEM stage (DM requester) of the 5-stage pipelined core.
- Arbitrates between the two requesters and registers the memory command.
- Returns read data with a one-cycle valid pulse, and generates stall_if / stall_mem toward the pipeline/hazard logic.
- Bounds IF starvation and memory non-response with a streak limit and a timeout.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 4, max consecutive DM grants while if_req is pending before IF is forced
TIMEOUT, 15, max cycles in a grant state waiting for mem_ack before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  fetch request; held until if_valid
if_addr  in  AW  fetch address
if_rdata  out  DW  fetch data, valid with if_valid
if_valid  out  1  one-cycle completion pulse for IF
dm_req  in  1  data request; held until dm_valid
dm_we  in  1  1=write, 0=read
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_rdata  out  DW  read data, valid with dm_valid
dm_valid  out  1  one-cycle completion pulse for DM
err  out  1  asserted with if_valid/dm_valid when the transaction timed out
mem_req  out  1  memory command valid (registered)
mem_we  out  1  memory write enable (registered)
mem_addr  out  AW  memory address (registered)
mem_wdata  out  DW  memory write data (registered)
mem_ack  in  1  memory completion; mem_rdata valid this cycle
mem_rdata  in  DW  memory read data
stall_if  out  1  combinational: if_req & ~if_valid
stall_mem  out  1  combinational: dm_req & ~dm_valid

Behaviour:

Reset:
- Reset is asynchronous and active-high, on port rst; single clock, clk.
- On rst: state=IDLE, streak=0, wait counter=0; all registered outputs (mem_*, *_rdata, *_valid, err) =0 immediately.
- Reset mid-transaction abandons it; no valid pulse is produced.

FSM states: IDLE, GNT_IF, GNT_DM, RESP.

IDLE:
- If dm_req and not (if_req and streak==STARVE_LIMIT): go to GNT_DM.
- Else if if_req: go to GNT_IF.
- Else: stay in IDLE.
- On the grant edge, latch addr/we/wdata from the winner into mem_*, set mem_req=1, clear the wait counter.
- IF grants force mem_we=0.

Streak counter:
- On a DM grant with if_req=1: streak+1, saturating at STARVE_LIMIT.
- On an IF grant, or a DM grant with if_req=0: streak=0.

GNT_IF / GNT_DM:
- Hold mem_* stable. Requester input changes after the grant are ignored.
- On mem_ack: mem_req=0; capture mem_rdata into the winner's rdata (reads only; dm_rdata is unchanged on writes); set the winner's valid=1 and err=0; go to RESP.
- Else if wait counter==TIMEOUT-1: mem_req=0; set the winner's valid=1, err=1, rdata=0 (reads only); go to RESP.
- Else: wait counter+1.
- mem_ack in IDLE/RESP is ignored.

RESP:
- Valid/err are high for exactly this cycle. No requests are sampled. Next state is IDLE; valid/err clear.
- A requester that keeps req high through RESP is re-arbitrated in IDLE as a new transaction.

Latency:
- Req sampled in IDLE at edge t gives mem_req high in cycle t+1.
- mem_ack in cycle t+1+k (k>=0) gives valid in cycle t+2+k.
- Minimum issue-to-valid is 2 cycles; minimum back-to-back spacing is 3 cycles.

Simultaneous requests: DM wins by default; IF wins when streak==STARVE_LIMIT.

mem_ack and timeout in the same cycle: ack takes precedence, err=0.

Decomposition:
- Shared package: FSM state enum (IDLE, GNT_IF, GNT_DM, RESP) and the requester-ID constants REQ_IF=0, REQ_DM=1. It is reused by the future hazard/stall integration.
- One sub-module, arb_timeout_counter: a loadable wait counter with a terminal-count flag, parameterised by TIMEOUT.
- Everything else is flat.

Test Plan:
- Single IF read, if_addr=0x10, mem_ack with mem_rdata=0xDEADBEEF 2 cycles after mem_req -> mem_addr=0x10, mem_we=0; if_valid one cycle with if_rdata=0xDEADBEEF, err=0; stall_if high until then.
- DM write, dm_addr=0x40, dm_wdata=0x1234, zero-wait ack (ack in the same cycle as mem_req) -> mem_we=1, mem_wdata=0x1234; dm_valid 2 cycles after the request is sampled; dm_rdata unchanged.
- if_req and dm_req held high continuously with immediate acks -> grant order DM,DM,DM,DM,IF repeating (STARVE_LIMIT=4); no duplicate or missing valids.
- mem_ack never asserted on an IF read -> if_valid=1, err=1, if_rdata=0 exactly TIMEOUT cycles after mem_req rose; FSM returns to IDLE.
- rst asserted while in GNT_DM (between edges) -> mem_req drops immediately; no dm_valid; after rst release with dm_req still high, a fresh transaction issues cleanly.
- Requester changes dm_addr from 0x40 to 0x80 during GNT_DM -> mem_addr stays 0x40 until ack.
